// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for a shared 16-bit memory port: instruction fetch (port 0) and data (port 1).
// Define ARB_FIXED_PRI_EN for fixed port-0 priority; the default is a round-robin tie-break.
module mem_port_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake: a requester raises reqN with we/addr/wdata valid and holds req until
  // its doneN pulse; inputs are sampled only at grant, and req must drop in the DONE
  // cycle, otherwise it is taken as a fresh request in the following IDLE cycle.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       we_q;
  logic       last;
  logic       win;
  logic       start;

  assign state_dbg = state;
  assign start     = (state == IDLE) && (req0 || req1);

`ifdef ARB_FIXED_PRI_EN
  assign win = ~req0;
`else
  // On a tie the port that did not win the previous tie goes first.
  assign win = (req0 && req1) ? ~last : req1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    done0  = 1'b0;
    done1  = 1'b0;
    mem_we = 1'b0;
    busy   = 1'b0;
    case (state)
      ACCESS: begin
        gnt0   = ~mem_sel;
        gnt1   = mem_sel;
        mem_we = we_q;
        busy   = 1'b1;
      end
      DONE: begin
        done0 = ~mem_sel;
        done1 = mem_sel;
        busy  = 1'b1;
      end
      default: ;
    endcase
  end

  // Request fields are captured once at grant and held through IDLE so the
  // memory side never sees the select or address glitch between accesses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      last      <= 1'b1;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else if (start) begin
      mem_sel   <= win;
      mem_addr  <= win ? addr1 : addr0;
      mem_wdata <= win ? wdata1 : wdata0;
      we_q      <= win ? we1 : we0;
      cnt       <= CNT_INIT;
`ifndef ARB_FIXED_PRI_EN
      if (req0 && req1) last <= win;
`endif
    end else if (state == ACCESS) begin
      if (cnt == 4'd0) begin
        if (!we_q) rdata <= mem_rdata;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter at MEM_LAT=2: reset, round-robin tie-break,
// reset mid-access, and a table of single-port reads/writes scored against an rdata queue.
module tb_mem_port_arbiter;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int MEM_LAT = 2;

  logic              clock;
  logic              reset_n;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1, mem_rdata;
  logic              gnt0, gnt1, done0, done1;
  logic [DATA_W-1:0] rdata;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we, busy;
  logic [1:0]        state_dbg;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .mem_rdata(mem_rdata),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mrd;
    logic [15:0] exp_rdata;
    logic        perturb;
  } vec_t;

  vec_t vecs[6];

  // driver + scoreboard push for one access; perturb drops req and scrambles inputs mid-access
  task automatic run_txn(input vec_t v);
    int cyc;
    int gcyc;
    chk("idle_before", state_dbg, 2'd0);
    mem_rdata = v.mrd;
    if (v.port) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
    exp_q.push_back(v.exp_rdata);
    tick;
    chk("grant_sel", mem_sel, v.port);
    chk("grant_wdata", mem_wdata, v.wdata);
    chk("grant_we", mem_we, v.we);
    chk("busy_access", busy, 1'b1);
    cyc  = 1;
    gcyc = 0;
    while (!(done0 || done1) && cyc < 20) begin
      chk("gnt_exclusive", gnt0 & gnt1, 1'b0);
      chk("mem_addr_hold", mem_addr, v.addr);
      if (v.port ? gnt1 : gnt0) gcyc++;
      if (v.perturb && cyc == 1) begin
        if (v.port) begin
          req1 = 1'b0; we1 = ~v.we; addr1 = v.addr + 16'h0010; wdata1 = ~v.wdata;
        end else begin
          req0 = 1'b0; we0 = ~v.we; addr0 = v.addr + 16'h0010; wdata0 = ~v.wdata;
        end
      end
      tick;
      cyc++;
    end
    chk("done_latency", cyc, MEM_LAT + 1);
    chk("gnt_cycles", gcyc, MEM_LAT);
    chk("done_port", {done1, done0}, v.port ? 2'b10 : 2'b01);
    chk("done_gnt_we_off", {gnt1, gnt0, mem_we}, 3'b000);
    chk("busy_done", busy, 1'b1);
    chk("sb_depth", exp_q.size(), 1);
    if (exp_q.size() != 0) chk("rdata", rdata, exp_q.pop_front());
    req0 = 1'b0;
    req1 = 1'b0;
    tick;
    chk("idle_after", {busy, done1, done0, gnt1, gnt0}, 5'b0);
    chk("mem_sel_hold", mem_sel, v.port);
    chk("mem_addr_hold_idle", mem_addr, v.addr);
  endtask

  initial begin
    logic [3:0] alt_exp;
`ifdef ARB_FIXED_PRI_EN
    alt_exp = 4'b0000;
`else
    alt_exp = 4'b1010;
`endif
    vecs[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 16'h8000, 16'h1234, 16'h5555, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'h8000, 16'h0000, 16'h1234, 16'h1234, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 16'h0040, 16'hAAAA, 16'h0F0F, 16'h1234, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hC3C3, 16'hC3C3, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0001, 16'h0001, 1'b1};

    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
    tick;
    tick;
    chk("reset_ctrl", {gnt0, gnt1, done0, done1, mem_we, busy, mem_sel}, 7'b0);
    chk("reset_addr", mem_addr, 16'h0);
    chk("reset_wdata", mem_wdata, 16'h0);
    chk("reset_rdata", rdata, 16'h0);
    reset_n = 1'b1;
    tick;
    chk("reset_state", state_dbg, 2'd0);

    // both ports requesting continuously
    req0 = 1'b1; req1 = 1'b1;
    addr0 = 16'h0100; addr1 = 16'h0200;
    wdata0 = 16'h1111; wdata1 = 16'h2222;
    mem_rdata = 16'h7777;
    for (int g = 0; g < 4; g++) begin
      int t;
      t = 0;
      while (!(gnt0 || gnt1) && t < 20) begin tick; t++; end
      chk("alt_onehot", gnt0 ^ gnt1, 1'b1);
      chk("alt_winner", gnt1, alt_exp[g]);
      t = 0;
      while (!(done0 || done1) && t < 20) begin tick; t++; end
      chk("alt_done", {done1, done0}, alt_exp[g] ? 2'b10 : 2'b01);
    end
    tick;
    tick;
    chk("pre_reset_access", gnt0 | gnt1, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midreset_ctrl", {gnt0, gnt1, done0, done1, mem_we, busy, mem_sel}, 7'b0);
    chk("midreset_addr", mem_addr, 16'h0);
    chk("midreset_wdata", mem_wdata, 16'h0);
    chk("midreset_rdata", rdata, 16'h0);
    chk("midreset_state", state_dbg, 2'd0);
    req0 = 1'b0; req1 = 1'b0;
    tick;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("post_reset_quiet", {state_dbg, done1, done0, busy}, 5'b0);
    end

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
